// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes from load-use,
// EX redirects and data-memory wait states, plus EX forwarding selects.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic             EX_memrd,
  input  logic             EX_wr_en,
  input  logic [4:0]       EX_wraddr,
  input  logic             EX_redirect,
  input  logic             MEM_wr_en,
  input  logic [4:0]       MEM_wraddr,
  input  logic             MEM_req,
  input  logic             WB_wr_en,
  input  logic [4:0]       WB_wraddr,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic        lu;
  logic        ms;
  logic        run_rules;
  logic        ms_eff;

  assign lu = EX_memrd && EX_wr_en && (EX_wraddr != 5'd0) &&
              ((ID_uses_rs && (ID_rs == EX_wraddr)) ||
               (ID_uses_rt && (ID_rt == EX_wraddr)));

  assign ms = MEM_req && !dmem_ack;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    run_rules = 1'b0;
    ms_eff    = 1'b0;
    case (state)
      S_RUN: begin
        run_rules = 1'b1;
        ms_eff    = ms;
        if (ms) begin
          state_nxt = S_WAIT;
          wait_nxt  = 16'd1;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          // The ack cycle behaves like RUN with the memory stall already cleared.
          run_rules = 1'b1;
          state_nxt = S_RUN;
          wait_nxt  = 16'd0;
        end else if (wait_cnt == TIMEOUT_V) begin
          state_nxt = S_ERROR;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
      S_ERROR: begin
        state_nxt = S_ERROR;
      end
      default: begin
        state_nxt = S_RUN;
        wait_nxt  = 16'd0;
      end
    endcase
  end

  always_comb begin
    dmem_req    = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if (rst) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end else if (run_rules) begin
      dmem_req = MEM_req;
      if (!ms_eff) begin
        pc_en     = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        if (EX_redirect) begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          // Hold PC and IF/ID, inject a single bubble into ID/EX.
          pc_en       = 1'b0;
          id_ex_flush = 1'b1;
        end else begin
          if_id_en = 1'b1;
        end
      end
    end else if (state == S_WAIT) begin
      dmem_req = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    if (MEM_wr_en && (MEM_wraddr != 5'd0) && (MEM_wraddr == EX_rs)) begin
      fwd_a = 2'b01;
    end else if (WB_wr_en && (WB_wraddr != 5'd0) && (WB_wraddr == EX_rs)) begin
      fwd_a = 2'b10;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (MEM_wr_en && (MEM_wraddr != 5'd0) && (MEM_wraddr == EX_rt)) begin
      fwd_b = 2'b01;
    end else if (WB_wr_en && (WB_wraddr != 5'd0) && (WB_wraddr == EX_rt)) begin
      fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign err = (state == S_ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT   = 4;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_memrd;
    logic       ex_wr_en;
    logic [4:0] ex_wraddr;
    logic       ex_redirect;
    logic       mem_wr_en;
    logic [4:0] mem_wraddr;
    logic       mem_req;
    logic       wb_wr_en;
    logic [4:0] wb_wraddr;
    logic       dmem_ack;
  } in_t;

  typedef struct packed {
    logic [7:0]       ctl;
    logic [3:0]       fwd;
    logic [CNT_W-1:0] stall;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  in_t  stim;

  logic             dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, mem_wb_en, err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  bit m_wait, m_err;
  int m_waited, m_stall;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(stim.id_rs), .ID_rt(stim.id_rt),
    .ID_uses_rs(stim.id_uses_rs), .ID_uses_rt(stim.id_uses_rt),
    .EX_rs(stim.ex_rs), .EX_rt(stim.ex_rt),
    .EX_memrd(stim.ex_memrd), .EX_wr_en(stim.ex_wr_en),
    .EX_wraddr(stim.ex_wraddr), .EX_redirect(stim.ex_redirect),
    .MEM_wr_en(stim.mem_wr_en), .MEM_wraddr(stim.mem_wraddr),
    .MEM_req(stim.mem_req), .WB_wr_en(stim.wb_wr_en),
    .WB_wraddr(stim.wb_wraddr), .dmem_ack(stim.dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .err(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] fwdSel(input logic [4:0] src, input in_t s);
    if (s.mem_wr_en && s.mem_wraddr != 0 && s.mem_wraddr == src) return 2'b01;
    if (s.wb_wr_en && s.wb_wraddr != 0 && s.wb_wraddr == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] dutCtl();
    return {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  // Predict this cycle's outputs, queue them, then advance the model across the next edge.
  task automatic predictCycle(input in_t s);
    exp_t       e;
    logic [7:0] ctl;
    bit         lu, ms;
    lu = s.ex_memrd && s.ex_wr_en && s.ex_wraddr != 0 &&
         ((s.id_uses_rs && s.id_rs == s.ex_wraddr) || (s.id_uses_rt && s.id_rt == s.ex_wraddr));
    ms = s.mem_req && !s.dmem_ack;
    if (m_err)                      ctl = 8'b0000_0000;
    else if (m_wait && !s.dmem_ack) ctl = 8'b1000_0000;
    else if (!m_wait && ms)         ctl = {s.mem_req, 7'b000_0000};
    else if (s.ex_redirect)         ctl = {s.mem_req, 7'b111_1111};
    else if (lu)                    ctl = {s.mem_req, 7'b000_1111};
    else                            ctl = {s.mem_req, 7'b110_1011};
    e.ctl   = ctl;
    e.fwd   = {fwdSel(s.ex_rs, s), fwdSel(s.ex_rt, s)};
    e.stall = m_stall[CNT_W-1:0];
    e.err   = m_err;
    sb.push_back(e);
    if (!ctl[6] && m_stall < STALL_MAX) m_stall++;
    if (!m_err) begin
      if (m_wait) begin
        if (s.dmem_ack) m_wait = 0;
        else if (m_waited == TIMEOUT) m_err = 1;
        else m_waited++;
      end else if (ms) begin
        m_wait   = 1;
        m_waited = 1;
      end
    end
  endtask

  task automatic applyStimulus(input in_t s);
    @(posedge clk);
    #1;
    stim = s;
    predictCycle(s);
  endtask

  task automatic modelReset();
    m_wait   = 0;
    m_err    = 0;
    m_waited = 0;
    m_stall  = 0;
  endtask

  // Pulse reset between edges and confirm the outputs respond without a clock.
  task automatic doReset();
    @(posedge clk);
    #2;
    stim = '0;
    rst  = 1'b1;
    #1;
    checkOutput("async_rst_ctl", 32'(dutCtl()), 32'h6B);
    checkOutput("async_rst_stall", 32'(stall_cnt), 32'h0);
    checkOutput("async_rst_err", 32'(err), 32'h0);
    modelReset();
    #1;
    rst = 1'b0;
    predictCycle(stim);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("ctl", 32'(dutCtl()), 32'(e.ctl));
        checkOutput("fwd", 32'({fwd_a, fwd_b}), 32'(e.fwd));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        checkOutput("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    in_t s;
    rst  = 1'b1;
    stim = '0;
    modelReset();
    #3;
    checkOutput("reset_ctl", 32'(dutCtl()), 32'h6B);
    checkOutput("reset_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    checkOutput("reset_stall", 32'(stall_cnt), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    #4;
    rst = 1'b0;

    s = '0; s.ex_memrd = 1; s.ex_wr_en = 1; s.ex_wraddr = 8; s.id_rs = 8; s.id_uses_rs = 1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);
    applyStimulus(s);

    s = '0; s.ex_memrd = 1; s.ex_wr_en = 1; s.ex_wraddr = 9; s.id_rt = 9; s.id_uses_rt = 1;
    s.ex_redirect = 1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    s = '0; s.mem_req = 1;
    repeat (3) applyStimulus(s);
    s.dmem_ack = 1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    s = '0; s.mem_req = 1;
    repeat (TIMEOUT) applyStimulus(s);
    s.dmem_ack = 1;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);

    s = '0; s.mem_req = 1;
    repeat (TIMEOUT + 2) applyStimulus(s);
    s.dmem_ack = 1;
    repeat (2) applyStimulus(s);
    s = '0;
    repeat (STALL_MAX + 2) applyStimulus(s);
    doReset();

    s = '0; s.mem_req = 1;
    repeat (2) applyStimulus(s);
    doReset();

    s = '0; s.mem_wr_en = 1; s.wb_wr_en = 1; s.mem_wraddr = 5; s.wb_wraddr = 5;
    s.ex_rs = 5; s.ex_rt = 5;
    applyStimulus(s);
    s.mem_wr_en = 0;
    applyStimulus(s);
    s.mem_wr_en = 1; s.mem_wraddr = 0; s.wb_wraddr = 0;
    applyStimulus(s);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        doReset();
      end else begin
        s.id_rs       = 5'($urandom_range(0, 3));
        s.id_rt       = 5'($urandom_range(0, 3));
        s.id_uses_rs  = 1'($urandom);
        s.id_uses_rt  = 1'($urandom);
        s.ex_rs       = 5'($urandom_range(0, 3));
        s.ex_rt       = 5'($urandom_range(0, 3));
        s.ex_memrd    = 1'($urandom);
        s.ex_wr_en    = 1'($urandom);
        s.ex_wraddr   = 5'($urandom_range(0, 3));
        s.ex_redirect = ($urandom_range(0, 6) == 0);
        s.mem_wr_en   = 1'($urandom);
        s.mem_wraddr  = 5'($urandom_range(0, 3));
        s.mem_req     = ($urandom_range(0, 2) == 0);
        s.wb_wr_en    = 1'($urandom);
        s.wb_wraddr   = 5'($urandom_range(0, 3));
        s.dmem_ack    = ($urandom_range(0, 9) < 4);
        applyStimulus(s);
      end
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Drives enable/flush of the PC and all four pipeline registers, including the MEM/WB register, from load-use hazards, EX-resolved redirects and data-memory wait states.
- Generates EX-stage forwarding selects.
- Keeps a stall performance counter and a sticky memory-timeout error.

Parameters:
TIMEOUT, 16, max MEM_WAIT cycles before ERROR (1..65535)
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
ID_rs  in  5  rs field of instruction in ID
ID_rt  in  5  rt field of instruction in ID
ID_uses_rs  in  1  ID instruction reads rs
ID_uses_rt  in  1  ID instruction reads rt
EX_rs  in  5  rs of instruction in EX
EX_rt  in  5  rt of instruction in EX
EX_memrd  in  1  EX instruction is a load
EX_wr_en  in  1  EX instruction writes register file
EX_wraddr  in  5  EX destination register
EX_redirect  in  1  taken branch/jump resolved in EX
MEM_wr_en  in  1  MEM instruction writes register file
MEM_wraddr  in  5  MEM destination register
MEM_req  in  1  MEM instruction is load/store
WB_wr_en  in  1  WB instruction writes register file
WB_wraddr  in  5  WB destination register
dmem_ack  in  1  data memory access complete this cycle
dmem_req  out  1  data memory request
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID capture enable
if_id_flush  out  1  IF/ID load bubble (all zeros)
id_ex_en  out  1  ID/EX capture enable
id_ex_flush  out  1  ID/EX load bubble
ex_mem_en  out  1  EX/MEM capture enable
mem_wb_en  out  1  MEM/WB capture enable
fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM ALUres, 10 MEM/WB result
fwd_b  out  2  EX operand B source, same encoding
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
err  out  1  sticky memory timeout

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset (async, rst=1): state=RUN, wait counter=0, stall_cnt=0, err=0. While in reset, all outputs are at RUN values with all inputs 0: enables 1, flushes 0, dmem_req 0, fwd 00.
- Load-use hazard (lu) = EX_memrd & EX_wr_en & EX_wraddr!=0 & ((ID_uses_rs & ID_rs==EX_wraddr) | (ID_uses_rt & ID_rt==EX_wraddr)).
- Memory stall (ms) = MEM_req & !dmem_ack.
- RUN, dmem_req=MEM_req (combinational):
  - ms: all enables 0, flushes 0. Go to MEM_WAIT, wait counter=1.
  - else EX_redirect: all enables 1, if_id_flush=1, id_ex_flush=1. Redirect beats lu.
  - else lu: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. Exactly one bubble. Next cycle the re-evaluated lu is 0 because EX then holds the bubble.
  - else: all enables 1, flushes 0.
- MEM_WAIT:
  - dmem_req=1, pipeline frozen (all enables 0, flushes 0), so all stage inputs are stable.
  - On dmem_ack: go to RUN. That same cycle, outputs follow the RUN rules with ms=0, so a held EX_redirect or lu is applied on the ack cycle.
  - If no ack and wait counter==TIMEOUT: go to ERROR. Otherwise wait counter +1.
  - Ack on the TIMEOUT cycle counts as success.
- ERROR: all enables 0, flushes 0, dmem_req=0, err=1. Left only by rst.
- Forwarding (combinational, independent of state):
  - fwd_a=01 if MEM_wr_en & MEM_wraddr!=0 & MEM_wraddr==EX_rs.
  - else fwd_a=10 if WB_wr_en & WB_wraddr!=0 & WB_wraddr==EX_rs.
  - else fwd_a=00.
  - fwd_b: same rules with EX_rt. MEM has priority over WB.
- stall_cnt: +1 each cycle pc_en=0, including ERROR. Saturates at all-ones.
- rst asserted mid-MEM_WAIT: immediate return to RUN, counters cleared, dmem_req drops asynchronously.

Test Plan:
- Load-use: EX_memrd=1, EX_wr_en=1, EX_wraddr=8, ID_rs=8, ID_uses_rs=1 for one cycle, then EX bubble -> cycle 0 pc_en=0, if_id_en=0, id_ex_flush=1. Cycle 1 all enables 1. stall_cnt=1.
- Redirect vs lu: EX_redirect=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait: MEM_req=1, dmem_ack low 3 cycles then high -> all enables 0 and dmem_req=1 for 3 cycles. Ack cycle enables 1, state RUN. stall_cnt=3.
- Timeout: TIMEOUT=4, MEM_req=1, no ack -> ERROR entered after 4th wait cycle, err=1, enables 0. Later ack ignored, err stays 1 until rst.
- Forwarding: MEM_wraddr=WB_wraddr=5, both wr_en=1, EX_rs=5, EX_rt=5 -> fwd_a=fwd_b=01. With MEM_wr_en=0 -> 10. With addr 0 -> 00.
- Async reset: rst pulsed mid-MEM_WAIT between clock edges -> dmem_req=0, stall_cnt=0, err=0 immediately, RUN outputs before next edge.
